priority_encoder_42: RTL and testbench
======================================

Name: priority_encoder_42

Overview:
- Registered 4-to-2 priority encoder. in[3] has the highest priority and in[0] the lowest.
- Reports the index of the highest-priority active request, a valid flag, a one-hot grant and a multiple-request flag.
- Sits in front of arbitration and interrupt-select logic. All outputs are registered, so downstream timing is isolated from request logic.

Parameters:
- None. Width is fixed at 4 requests and a 2-bit index.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  capture enable; 0 = hold all registered outputs
- in  input  4  request vector; bit n = request n
- mask  input  4  per-request mask; 1 = request ignored
- out  output  2  index of highest-priority unmasked active request
- valid  output  1  1 = at least one unmasked request was active
- onehot  output  4  one-hot form of out; all zero when valid=0
- multi  output  1  1 = two or more unmasked requests were active
- changed  output  1  one-cycle pulse when out or valid differs from the previous captured value

Behaviour:
- Effective request vector: req = in & ~mask.
- Encoding is combinational on req, then registered:
  - req[3]=1 -> out=11
  - else req[2]=1 -> out=10
  - else req[1]=1 -> out=01
  - else req[0]=1 -> out=00, valid=1
  - req=0000 -> out=00, valid=0
- Priority: bit 3 > 2 > 1 > 0. Lower bits are don't-care once a higher bit is set.
- Full truth table: 0000->00/0; 0001->00/1; 001x->01/1; 01xx->10/1; 1xxx->11/1.
- onehot = 1 << out when valid=1, else 0000.
- multi = 1 when popcount(req) >= 2.
- Latency: exactly 1 clk. Values sampled at edge k appear on outputs after edge k and hold until the next capturing edge.
- en=0: out, valid, onehot and multi hold their values; changed is driven 0.
- changed: registered. It is 1 for exactly one cycle after a capturing edge (en=1) at which the newly captured {out,valid} differs from the previous registered {out,valid}; otherwise 0.
- Reset (rst=1 at rising edge): out=00, valid=0, onehot=0000, multi=0, changed=0.
  - Reset has priority over en.
  - Reset during an active request clears outputs; the first capture after rst deasserts compares against the reset value {00,0}.
- X-free: no latches; every output has a defined value from the first clock edge with rst high.

Optional Feature:
- Macro: PENC_COUNT_EN
- Defined: adds output port count (3 bits, registered, same latency/enable/reset rules as out). count = popcount(req), range 0..4, reset value 000.
- Undefined: the count port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst with in=1111, en=1 -> after edge: out=00, valid=0, onehot=0000, multi=0, changed=0.
- Exhaustive sweep: mask=0000, en=1, in=0000..1111 one per cycle. One cycle later each result matches the truth table, e.g. 0000->00/0, 0011->01/1, 0111->10/1, 1010->11/1; multi=1 for 0011 and 1111; onehot=1000 for 1xxx.
- Masking: in=1111, mask=1100 -> out=01, valid=1, onehot=0010, multi=1; mask=1111 -> valid=0, out=00.
- Enable hold: capture in=0100 (out=10), then en=0 with in=1000 for 3 cycles -> out stays 10, changed=0; re-enable -> out=11 and changed=1 for one cycle.
- changed pulse: in held at 0010 for 4 cycles -> changed=1 only on the first result cycle, then 0. Switching to 0011 -> out still 01, changed stays 0.
- PENC_COUNT_EN build: in=1011, mask=0000 -> count=011; in=1111 -> count=100; rst -> count=000.

Source files
------------

// File: rtl/priority_encoder_42.sv
// Registered 4-to-2 priority encoder (bit 3 highest) with valid, one-hot grant, multi-request and change flags.
// Define PENC_COUNT_EN to add a registered popcount output 'count'.
module priority_encoder_42 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] in,
   input  logic [3:0] mask,
   output logic [1:0] out,
   output logic       valid,
   output logic [3:0] onehot,
   output logic       multi,
   output logic       changed
`ifdef PENC_COUNT_EN
   ,
   output logic [2:0] count
`endif
);

   function automatic logic [1:0] f_encode(input logic [3:0] req);
      logic [1:0] idx;
      idx = 2'b00;
      if (req[3])      idx = 2'b11;
      else if (req[2]) idx = 2'b10;
      else if (req[1]) idx = 2'b01;
      else             idx = 2'b00;
      return idx;
   endfunction

   function automatic logic [3:0] f_onehot(input logic [1:0] idx, input logic vld);
      logic [3:0] oh;
      oh = 4'b0000;
      if (vld) oh[idx] = 1'b1;
      return oh;
   endfunction

   function automatic logic [2:0] f_popcount(input logic [3:0] req);
      return {2'b00, req[0]} + {2'b00, req[1]} + {2'b00, req[2]} + {2'b00, req[3]};
   endfunction

   logic [3:0] w_req;
   logic [1:0] w_out;
   logic       w_valid;
   logic [3:0] w_onehot;
   logic [2:0] w_pop;
   logic       w_multi;
   logic       w_diff;

   logic [1:0] r_out;
   logic       r_valid;
   logic [3:0] r_onehot;
   logic       r_multi;
   logic       r_changed;

   // Encode stage: combinational on the masked request vector
   always_comb begin
      w_req    = in & ~mask;
      w_out    = f_encode(w_req);
      w_valid  = |w_req;
      w_onehot = f_onehot(w_out, w_valid);
      w_pop    = f_popcount(w_req);
      w_multi  = (w_pop >= 3'd2);
      w_diff   = ({w_out, w_valid} != {r_out, r_valid});
   end

   // Output register stage; changed compares against the previously held result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out     <= 2'b00;
         r_valid   <= 1'b0;
         r_onehot  <= 4'b0000;
         r_multi   <= 1'b0;
         r_changed <= 1'b0;
      end else if (en) begin
         r_out     <= w_out;
         r_valid   <= w_valid;
         r_onehot  <= w_onehot;
         r_multi   <= w_multi;
         r_changed <= w_diff;
      end else begin
         r_changed <= 1'b0;
      end
   end

`ifdef PENC_COUNT_EN
   logic [2:0] r_count;

   always_ff @(posedge clk) begin
      if (rst)     r_count <= 3'b000;
      else if (en) r_count <= w_pop;
   end

   assign count = r_count;
`endif

   assign out     = r_out;
   assign valid   = r_valid;
   assign onehot  = r_onehot;
   assign multi   = r_multi;
   assign changed = r_changed;

endmodule

// File: tb/tb_priority_encoder_42.sv
// Directed self-checking bench for priority_encoder_42 with hand-computed expected values.
module tb_priority_encoder_42;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] in;
   logic [3:0] mask;
   logic [1:0] out;
   logic       valid;
   logic [3:0] onehot;
   logic       multi;
   logic       changed;
`ifdef PENC_COUNT_EN
   logic [2:0] count;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Hand-computed truth table for in = 0..15 with mask = 0, sweep started from reset state
   logic [1:0] exp_out     [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                    2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
   logic       exp_valid   [16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [3:0] exp_onehot  [16] = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4,
                                    4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
   logic       exp_multi   [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic       exp_changed [16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   priority_encoder_42 dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .in      (in),
      .mask    (mask),
      .out     (out),
      .valid   (valid),
      .onehot  (onehot),
      .multi   (multi),
      .changed (changed)
`ifdef PENC_COUNT_EN
      ,
      .count   (count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] e_out, input logic e_valid,
                          input logic [3:0] e_onehot, input logic e_multi, input logic e_changed);
      chk({tag, ".out"},     {30'd0, out},     {30'd0, e_out});
      chk({tag, ".valid"},   {31'd0, valid},   {31'd0, e_valid});
      chk({tag, ".onehot"},  {28'd0, onehot},  {28'd0, e_onehot});
      chk({tag, ".multi"},   {31'd0, multi},   {31'd0, e_multi});
      chk({tag, ".changed"}, {31'd0, changed}, {31'd0, e_changed});
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; in = 4'b0000; mask = 4'b0000;
      tick();
      chk_all("init_reset", 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);

      // Load a nonzero result, then reset with requests still active
      rst = 1'b0; in = 4'b1111;
      tick();
      chk_all("pre_reset", 2'b11, 1'b1, 4'b1000, 1'b1, 1'b1);
      rst = 1'b1;
      tick();
      chk_all("reset_active_req", 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);

      // Exhaustive sweep from reset state
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in = i[3:0];
         tick();
         chk_all($sformatf("sweep_%0d", i), exp_out[i], exp_valid[i], exp_onehot[i],
                 exp_multi[i], exp_changed[i]);
      end

      // Masking
      in = 4'b1111; mask = 4'b1100;
      tick();
      chk_all("mask_1100", 2'b01, 1'b1, 4'b0010, 1'b1, 1'b1);
      mask = 4'b1111;
      tick();
      chk_all("mask_1111", 2'b00, 1'b0, 4'b0000, 1'b0, 1'b1);
      mask = 4'b0110; in = 4'b0111;
      tick();
      chk_all("mask_0110", 2'b00, 1'b1, 4'b0001, 1'b0, 1'b1);
      mask = 4'b0000;

      // Enable hold
      in = 4'b0100;
      tick();
      chk_all("hold_capture", 2'b10, 1'b1, 4'b0100, 1'b0, 1'b1);
      en = 1'b0; in = 4'b1011;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("hold_%0d", k), 2'b10, 1'b1, 4'b0100, 1'b0, 1'b0);
      end
      en = 1'b1;
      tick();
      chk_all("reenable", 2'b11, 1'b1, 4'b1000, 1'b1, 1'b1);
      tick();
      chk_all("reenable_steady", 2'b11, 1'b1, 4'b1000, 1'b1, 1'b0);

      // changed pulse on a held input
      in = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_all($sformatf("pulse_%0d", k), 2'b01, 1'b1, 4'b0010, 1'b0, (k == 0));
      end
      in = 4'b0011;
      tick();
      chk_all("same_index_multi", 2'b01, 1'b1, 4'b0010, 1'b1, 1'b0);

      // Reset takes priority over en=0
      en = 1'b0; rst = 1'b1; in = 4'b1000;
      tick();
      chk_all("reset_over_en", 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);

      // First capture after reset compares against {00,0}
      rst = 1'b0; en = 1'b1; in = 4'b0000;
      tick();
      chk_all("post_reset_zero", 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
      in = 4'b0001;
      tick();
      chk_all("post_reset_bit0", 2'b00, 1'b1, 4'b0001, 1'b0, 1'b1);

`ifdef PENC_COUNT_EN
      in = 4'b1011; mask = 4'b0000;
      tick();
      chk("count_1011", {29'd0, count}, 32'd3);
      in = 4'b1111;
      tick();
      chk("count_1111", {29'd0, count}, 32'd4);
      en = 1'b0; in = 4'b0001;
      tick();
      chk("count_hold", {29'd0, count}, 32'd4);
      rst = 1'b1;
      tick();
      chk("count_reset", {29'd0, count}, 32'd0);
      rst = 1'b0; en = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
